// File: rtl/bus_arb_pkg.sv
// Shared encodings, idle-bus constants and owner-index width for the bus arbiter.
// Combinational constants only, no latency or backpressure.
package bus_arb_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int   IDLE_ADDR = 0;
    localparam int   IDLE_DATA = 0;
    localparam logic IDLE_AS_  = DISABLE_;
    localparam logic IDLE_RW   = READ;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic int own_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arb_mux_rr_pick.sv
// Rotate-priority find-first: first set bit of req scanning ptr, ptr+1, ... mod N.
// Purely combinational, zero latency; no backpressure.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = own_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         vld,
    output logic [W-1:0] idx
);

    // Scan in reverse rotate order so the last hit is the highest-priority one.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                vld = 1'b1;
                idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Round-robin bus arbiter plus master-to-slave mux; BUS_ARB_TIMEOUT_EN adds forced revoke.
// Grant registered one cycle after request; s_* follow the registered grant combinationally.
module bus_arb_mux
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req_,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_as_,
    input  logic [N_MASTERS-1:0]          m_rw,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wr_data,
    output logic [N_MASTERS-1:0]          m_grnt_,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_as_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    output logic [own_w(N_MASTERS)-1:0]   arb_owner,
    output logic                          arb_busy,
    output logic                          arb_timeout
);

    localparam int OWN_W = own_w(N_MASTERS);

    arb_state_t             state;
    logic [OWN_W-1:0]       owner;
    logic [OWN_W-1:0]       ptr;
    logic [N_MASTERS-1:0]   owner_oh;
    logic [N_MASTERS-1:0]   elig;
    logic                   owner_rel;
    logic                   revoke;
    logic                   handover;
    logic                   pick_vld;
    logic [OWN_W-1:0]       pick_idx;
    logic [OWN_W-1:0]       ptr_nxt;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]       cnt;
    logic [N_MASTERS-1:0]   mask;
    logic                   tmo_q;
`endif

    assign owner_oh  = N_MASTERS'(1) << owner;
    assign owner_rel = (state == ST_BUSY) && m_req_[owner];

    always_comb begin
        revoke = 1'b0;
        elig   = ~m_req_;
`ifdef BUS_ARB_TIMEOUT_EN
        revoke = (state == ST_BUSY) && !m_req_[owner] && (cnt == CNT_W'(TIMEOUT - 1));
        // The revoked owner is still requesting, so exclude it explicitly this edge.
        elig   = ~m_req_ & ~mask & ~(revoke ? owner_oh : '0);
`endif
    end

    assign handover = (state == ST_IDLE) || owner_rel || revoke;
    assign ptr_nxt  = (pick_idx == OWN_W'(N_MASTERS - 1)) ? '0 : pick_idx + OWN_W'(1);

    rr_pick #(.N(N_MASTERS), .W(OWN_W)) u_pick (
        .req (elig),
        .ptr (ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= '0;
            ptr     <= '0;
            m_grnt_ <= {N_MASTERS{DISABLE_}};
`ifdef BUS_ARB_TIMEOUT_EN
            cnt     <= '0;
            mask    <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_q <= revoke;
            mask  <= (mask & ~m_req_) | (revoke ? owner_oh : '0);
            if (!handover) cnt <= cnt + CNT_W'(1);
`endif
            if (handover) begin
                if (pick_vld) begin
                    state   <= ST_BUSY;
                    owner   <= pick_idx;
                    ptr     <= ptr_nxt;
                    m_grnt_ <= ~(N_MASTERS'(1) << pick_idx);
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt     <= '0;
`endif
                end else begin
                    state   <= ST_IDLE;
                    m_grnt_ <= {N_MASTERS{DISABLE_}};
                end
            end
        end
    end

    assign arb_busy  = (state == ST_BUSY);
    assign arb_owner = owner;
`ifdef BUS_ARB_TIMEOUT_EN
    assign arb_timeout = tmo_q;
`else
    assign arb_timeout = 1'b0;
`endif

    always_comb begin
        s_addr    = ADDR_W'(IDLE_ADDR);
        s_as_     = IDLE_AS_;
        s_rw      = IDLE_RW;
        s_wr_data = DATA_W'(IDLE_DATA);
        if (state == ST_BUSY) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (owner == OWN_W'(i)) begin
                    s_addr    = m_addr[i*ADDR_W +: ADDR_W];
                    s_as_     = m_as_[i];
                    s_rw      = m_rw[i];
                    s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed testbench for bus_arb_mux (4 masters, TIMEOUT=8; timeout scenario with BUS_ARB_TIMEOUT_EN).
module tb_bus_arb_mux;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    m_req_ = '1;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_as_ = 4'b1010;
    logic [N-1:0]    m_rw  = 4'b0110;
    logic [N*DW-1:0] m_wr_data;
    logic [N-1:0]    m_grnt_;
    logic [AW-1:0]   s_addr;
    logic            s_as_;
    logic            s_rw;
    logic [DW-1:0]   s_wr_data;
    logic [1:0]      arb_owner;
    logic            arb_busy;
    logic            arb_timeout;

    int tests = 0;
    int fails = 0;

    bus_arb_mux #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_),
        .m_rw(m_rw), .m_wr_data(m_wr_data), .m_grnt_(m_grnt_), .s_addr(s_addr),
        .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data), .arb_owner(arb_owner),
        .arb_busy(arb_busy), .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] ea(input int i);
        return 30'h100 + 30'(i);
    endfunction

    function automatic logic [DW-1:0] ed(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        m_req_ = '1;
        step();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (m_grnt_ !== 4'b1111) begin fails++; $display("FAIL reset_grnt got %b exp 1111", m_grnt_); end
        tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", arb_busy); end
        tests++; if (arb_owner !== 2'd0) begin fails++; $display("FAIL reset_owner got %0d exp 0", arb_owner); end
        tests++; if (s_as_ !== 1'b1 || s_rw !== 1'b1) begin fails++; $display("FAIL reset_as_rw got %b%b exp 11", s_as_, s_rw); end
        tests++; if (s_addr !== '0 || s_wr_data !== '0) begin fails++; $display("FAIL reset_addr_data got %h/%h exp 0/0", s_addr, s_wr_data); end
        tests++; if (arb_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", arb_timeout); end
    endtask

    task automatic test_first_grant();
        do_reset();
        m_req_ = 4'b1110;
        tests++; if (m_grnt_ !== 4'b1111) begin fails++; $display("FAIL grant_latency got %b exp 1111", m_grnt_); end
        step();
        tests++; if (m_grnt_ !== 4'b1110) begin fails++; $display("FAIL first_grnt got %b exp 1110", m_grnt_); end
        tests++; if (arb_busy !== 1'b1 || arb_owner !== 2'd0) begin fails++; $display("FAIL first_owner got %b/%0d exp 1/0", arb_busy, arb_owner); end
        tests++; if (s_addr !== ea(0) || s_wr_data !== ed(0)) begin fails++; $display("FAIL first_mux_data got %h/%h exp %h/%h", s_addr, s_wr_data, ea(0), ed(0)); end
        tests++; if (s_as_ !== 1'b0 || s_rw !== 1'b0) begin fails++; $display("FAIL first_mux_ctl got %b%b exp 00", s_as_, s_rw); end
        m_req_ = 4'b1111;
        step();
        tests++; if (m_grnt_ !== 4'b1111 || arb_busy !== 1'b0 || s_as_ !== 1'b1) begin fails++; $display("FAIL release_idle got %b/%b/%b exp 1111/0/1", m_grnt_, arb_busy, s_as_); end
        // ptr is now 1, so master 2 beats master 0
        m_req_ = 4'b1010;
        step();
        tests++; if (m_grnt_ !== 4'b1011 || arb_owner !== 2'd2) begin fails++; $display("FAIL ptr_after_first got %b/%0d exp 1011/2", m_grnt_, arb_owner); end
        m_addr[2*AW +: AW] = 30'h2ABCD;
        #1;
        tests++; if (s_addr !== 30'h2ABCD) begin fails++; $display("FAIL mux_comb got %h exp 2abcd", s_addr); end
        m_addr[2*AW +: AW] = ea(2);
        m_req_ = '1;
        step();
    endtask

    task automatic test_rr_order();
        int seq[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        do_reset();
        m_req_ = 4'b0000;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_g = ~(4'b0001 << seq[k]);
            for (int c = 0; c < 3; c++) begin
                tests++;
                if (m_grnt_ !== exp_g || arb_owner !== 2'(seq[k])) begin
                    fails++; $display("FAIL rr_slot%0d_cyc%0d got %b/%0d exp %b/%0d", k, c, m_grnt_, arb_owner, exp_g, seq[k]);
                end
                if (c < 2) step();
            end
            m_req_[seq[k]] = 1'b1;
            step();
            m_req_[seq[k]] = 1'b0;
        end
        m_req_ = '1;
        step();
        tests++; if (arb_busy !== 1'b0 || m_grnt_ !== 4'b1111) begin fails++; $display("FAIL rr_end_idle got %b/%b exp 0/1111", arb_busy, m_grnt_); end
    endtask

    task automatic test_no_preempt();
        do_reset();
        m_req_ = 4'b1011;
        step();
        m_req_ = 4'b1010;
        step();
        step();
        tests++; if (m_grnt_ !== 4'b1011 || arb_owner !== 2'd2) begin fails++; $display("FAIL no_preempt got %b/%0d exp 1011/2", m_grnt_, arb_owner); end
        m_req_ = 4'b0110;
        step();
        tests++; if (m_grnt_ !== 4'b0111 || arb_owner !== 2'd3) begin fails++; $display("FAIL handover_to3 got %b/%0d exp 0111/3", m_grnt_, arb_owner); end
        tests++; if (s_addr !== ea(3) || s_wr_data !== ed(3) || s_rw !== 1'b0 || s_as_ !== 1'b1) begin fails++; $display("FAIL mux_m3 got %h/%h/%b/%b", s_addr, s_wr_data, s_rw, s_as_); end
        do_reset();
        m_req_ = 4'b1011;
        step();
        m_req_ = 4'b1010;
        step();
        m_req_ = 4'b1110;
        step();
        tests++; if (m_grnt_ !== 4'b1110 || arb_owner !== 2'd0) begin fails++; $display("FAIL handover_to0 got %b/%0d exp 1110/0", m_grnt_, arb_owner); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_req_ = 4'b1101;
        step();
        tests++; if (m_grnt_ !== 4'b1101) begin fails++; $display("FAIL mid_pre got %b exp 1101", m_grnt_); end
        reset = 1'b1;
        step();
        tests++; if (m_grnt_ !== 4'b1111 || arb_busy !== 1'b0 || s_as_ !== 1'b1 || s_addr !== '0) begin fails++; $display("FAIL mid_reset got %b/%b/%b/%h", m_grnt_, arb_busy, s_as_, s_addr); end
        reset  = 1'b0;
        m_req_ = 4'b1100;
        step();
        tests++; if (m_grnt_ !== 4'b1110) begin fails++; $display("FAIL mid_m0_wins got %b exp 1110", m_grnt_); end
        m_req_ = 4'b1101;
        step();
        tests++; if (m_grnt_ !== 4'b1101) begin fails++; $display("FAIL mid_m1_next got %b exp 1101", m_grnt_); end
        do_reset();
        m_req_ = 4'b1101;
        step();
        tests++; if (m_grnt_ !== 4'b1101 || arb_owner !== 2'd1) begin fails++; $display("FAIL mid_m1_alone got %b/%0d exp 1101/1", m_grnt_, arb_owner); end
        m_req_ = '1;
        step();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        m_req_ = 4'b1100;
        step();
        for (int c = 0; c < 8; c++) begin
            tests++;
            if (m_grnt_ !== 4'b1110 || arb_timeout !== 1'b0) begin
                fails++; $display("FAIL tmo_hold_cyc%0d got %b/%b exp 1110/0", c, m_grnt_, arb_timeout);
            end
            step();
        end
        tests++; if (m_grnt_ !== 4'b1101 || arb_timeout !== 1'b1) begin fails++; $display("FAIL tmo_revoke got %b/%b exp 1101/1", m_grnt_, arb_timeout); end
        step();
        tests++; if (arb_timeout !== 1'b0 || m_grnt_ !== 4'b1101) begin fails++; $display("FAIL tmo_pulse_len got %b/%b exp 0/1101", arb_timeout, m_grnt_); end
        m_req_ = 4'b1110;
        step();
        step();
        tests++; if (m_grnt_ !== 4'b1111 || arb_busy !== 1'b0) begin fails++; $display("FAIL tmo_masked got %b/%b exp 1111/0", m_grnt_, arb_busy); end
        m_req_ = 4'b1111;
        step();
        m_req_ = 4'b1110;
        step();
        tests++; if (m_grnt_ !== 4'b1110) begin fails++; $display("FAIL tmo_unmasked got %b exp 1110", m_grnt_); end
        m_req_ = '1;
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]    = ea(i);
            m_wr_data[i*DW +: DW] = ed(i);
        end
        test_reset();
        test_first_grant();
        test_rr_order();
        test_no_preempt();
        test_reset_mid();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
